// File: rtl/pulse_trigger.sv
// Baseline-subtracted threshold trigger: captures a fixed window after each
// crossing and emits peak, charge (including pre-trigger samples) and timestamp.
module pulse_trigger #(
    parameter int THRESH  = 50,
    parameter int PRESAMP = 4,
    parameter int WINDOW  = 32,
    parameter int HOLDOFF = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] indata,
    input  logic [13:0] baseline,
    input  logic        bl_done,
    input  logic        enable,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [13:0] evt_peak,
    output logic [19:0] evt_charge,
    output logic [31:0] evt_time,
    output logic        busy,
    output logic [15:0] lost_cnt
);

    typedef enum logic [1:0] {
        S_WAIT_BL,
        S_ARMED,
        S_CAPTURE,
        S_HOLDOFF
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [13:0] r_amp;
    logic [31:0] r_tcnt;
    logic [31:0] r_tcnt_d;
    logic [13:0] r_pre [PRESAMP];
    logic [19:0] r_pre_sum;
    logic [19:0] r_charge;
    logic [13:0] r_peak;
    logic [31:0] r_t_trig;
    logic [6:0]  r_wcnt;
    logic [7:0]  r_hcnt;

    logic        w_run;
    logic        w_trig;
    logic        w_commit;
    logic        w_slot_free;
    logic [19:0] w_charge_acc;
    logic [13:0] w_peak_acc;

    assign w_run        = enable & bl_done;
    assign w_trig       = (r_amp >= 14'(THRESH));
    assign w_charge_acc = r_charge + 20'(r_amp);
    assign w_peak_acc   = (r_amp > r_peak) ? r_amp : r_peak;
    assign w_slot_free  = ~evt_valid | evt_ready;
    assign busy         = (r_state == S_CAPTURE) || (r_state == S_HOLDOFF);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_WAIT_BL;
        else        r_state <= w_state_next;
    end

    // NOTE: defaults assigned first so no path through the case leaves an
    // output unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        if (!w_run) begin
            w_state_next = S_WAIT_BL;
        end else begin
            case (r_state)
                S_WAIT_BL: w_state_next = S_ARMED;
                S_ARMED:   if (w_trig) w_state_next = S_CAPTURE;
                S_CAPTURE: begin
                    if (r_wcnt == 7'(WINDOW - 1)) begin
                        w_commit     = 1'b1;
                        w_state_next = (HOLDOFF == 0) ? S_ARMED : S_HOLDOFF;
                    end
                end
                S_HOLDOFF: if (r_hcnt == 8'(HOLDOFF - 1)) w_state_next = S_ARMED;
                default:   w_state_next = S_WAIT_BL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_amp      <= '0;
            r_tcnt     <= '0;
            r_tcnt_d   <= '0;
            // NOTE: the pre-trigger line is a short shift register that must
            // read as zero after reset, so it is reset like ordinary flops.
            for (int i = 0; i < PRESAMP; i++) r_pre[i] <= '0;
            r_pre_sum  <= '0;
            r_charge   <= '0;
            r_peak     <= '0;
            r_t_trig   <= '0;
            r_wcnt     <= '0;
            r_hcnt     <= '0;
            evt_valid  <= 1'b0;
            evt_peak   <= '0;
            evt_charge <= '0;
            evt_time   <= '0;
            lost_cnt   <= '0;
        end else begin
            r_amp    <= (indata >= baseline) ? (indata - baseline) : 14'd0;
            r_tcnt   <= r_tcnt + 32'd1;
            r_tcnt_d <= r_tcnt;

            if (r_state == S_WAIT_BL) begin
                for (int i = 0; i < PRESAMP; i++) r_pre[i] <= '0;
                r_pre_sum <= '0;
            end else begin
                r_pre[0] <= r_amp;
                for (int i = 1; i < PRESAMP; i++) r_pre[i] <= r_pre[i-1];
                r_pre_sum <= r_pre_sum + 20'(r_amp) - 20'(r_pre[PRESAMP-1]);
            end

            // Trigger sample opens the window with the pre-trigger sum folded in.
            if (r_state == S_ARMED && w_trig) begin
                r_charge <= r_pre_sum + 20'(r_amp);
                r_peak   <= r_amp;
                r_t_trig <= r_tcnt_d;
                r_wcnt   <= 7'd1;
            end else if (r_state == S_CAPTURE) begin
                r_charge <= w_charge_acc;
                r_peak   <= w_peak_acc;
                r_wcnt   <= r_wcnt + 7'd1;
            end

            if (r_state == S_HOLDOFF) r_hcnt <= r_hcnt + 8'd1;
            else                      r_hcnt <= '0;

            if (w_commit && w_slot_free) begin
                evt_valid  <= 1'b1;
                evt_peak   <= w_peak_acc;
                evt_charge <= w_charge_acc;
                evt_time   <= r_t_trig;
            end else if (evt_ready) begin
                evt_valid  <= 1'b0;
            end

            if (w_commit && !w_slot_free && lost_cnt != 16'hFFFF)
                lost_cnt <= lost_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pulse_trigger.sv
// Scoreboard bench for pulse_trigger: stimulus pushes expected records, a
// negedge monitor pops and compares them at each accepted handshake.
module tb_pulse_trigger;

    localparam int WINDOW  = 8;
    localparam int HOLDOFF = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] indata;
    logic [13:0] baseline;
    logic        bl_done;
    logic        enable;
    logic        evt_valid;
    logic        evt_ready;
    logic [13:0] evt_peak;
    logic [19:0] evt_charge;
    logic [31:0] evt_time;
    logic        busy;
    logic [15:0] lost_cnt;

    pulse_trigger #(
        .THRESH (50),
        .PRESAMP(4),
        .WINDOW (WINDOW),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .indata    (indata),
        .baseline  (baseline),
        .bl_done   (bl_done),
        .enable    (enable),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_peak  (evt_peak),
        .evt_charge(evt_charge),
        .evt_time  (evt_time),
        .busy      (busy),
        .lost_cnt  (lost_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] peak;
        logic [19:0] charge;
        logic [31:0] tim;
        logic [31:0] rise;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cyc;
    logic        prev_valid = 1'b0;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [13:0] v;

    // Reference free-running timestamp.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= cyc + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [13:0] peak, input logic [19:0] charge, input logic [31:0] tim);
        exp_t e;
        e.peak   = peak;
        e.charge = charge;
        e.tim    = tim;
        e.rise   = tim + 32'(WINDOW + 1);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [13:0] val);
        @(posedge clk);
        #1;
        indata = val;
    endtask

    task automatic idle(input int n);
        repeat (n) step(14'd1000);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (evt_valid && !prev_valid && exp_q.size() != 0)
                check("evt_latency", cyc, exp_q[0].rise);
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: peak %0d charge %0d time %0d, none expected",
                             evt_peak, evt_charge, evt_time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("evt_peak",   32'(evt_peak),   32'(mon_e.peak));
                    check("evt_charge", 32'(evt_charge), 32'(mon_e.charge));
                    check("evt_time",   evt_time,        mon_e.tim);
                end
            end
        end
        prev_valid = evt_valid;
    end

    initial begin
        rst_n     = 1'b0;
        indata    = 14'd1000;
        baseline  = 14'd1000;
        bl_done   = 1'b1;
        enable    = 1'b1;
        evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_evt_valid",  32'(evt_valid),  0);
        check("rst_evt_peak",   32'(evt_peak),   0);
        check("rst_evt_charge", 32'(evt_charge), 0);
        check("rst_evt_time",   evt_time,        0);
        check("rst_busy",       32'(busy),       0);
        check("rst_lost_cnt",   32'(lost_cnt),   0);
        rst_n = 1'b1;
        idle(10);

        // Single pulse with busy profile over the window and holdoff.
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       v = 14'd1100;
                1:       v = 14'd1300;
                2:       v = 14'd1200;
                3:       v = 14'd1050;
                default: v = 14'd1000;
            endcase
            step(v);
            if (i == 0) begin
                t0 = cyc;
                push_exp(14'd300, 20'd650, t0);
            end
            @(negedge clk);
            check("busy_profile", 32'(busy), 32'(i >= 2 && i <= 12));
        end
        idle(10);

        // Pre-trigger samples with a below-baseline value clipped to zero.
        step(14'd1020);
        step(14'd1030);
        step(14'd990);
        step(14'd1040);
        step(14'd1100);
        push_exp(14'd100, 20'd190, cyc);
        idle(20);

        // Holdoff: crossing at t+9 ignored, t+13 accepted with t+9 in its pre-sum.
        step(14'd1100);
        t0 = cyc;
        push_exp(14'd100, 20'd100, t0);
        idle(8);
        step(14'd1100);
        idle(3);
        step(14'd1100);
        check("holdoff_rearm_cycle", cyc, t0 + 32'd13);
        push_exp(14'd100, 20'd200, cyc);
        idle(20);
        check("holdoff_lost_cnt", 32'(lost_cnt), 0);

        // Backpressure: first record held, next two dropped.
        evt_ready = 1'b0;
        step(14'd1100);
        t1 = cyc;
        push_exp(14'd100, 20'd100, t1);
        idle(19);
        step(14'd1200);
        idle(19);
        step(14'd1300);
        idle(15);
        @(negedge clk);
        check("bp_valid_held",  32'(evt_valid),  1);
        check("bp_peak_held",   32'(evt_peak),   100);
        check("bp_charge_held", 32'(evt_charge), 100);
        check("bp_time_held",   evt_time,        t1);
        check("bp_lost_cnt",    32'(lost_cnt),   2);
        step(14'd1000);
        evt_ready = 1'b1;
        step(14'd1000);
        evt_ready = 1'b0;
        @(negedge clk);
        check("bp_valid_cleared", 32'(evt_valid), 0);
        evt_ready = 1'b1;
        idle(5);

        // Abort at window sample 4; re-armed trigger sees a cleared pre-sum.
        step(14'd1100);
        step(14'd1300);
        step(14'd1200);
        step(14'd1050);
        enable = 1'b0;
        step(14'd1000);
        enable = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        step(14'd1100);
        push_exp(14'd100, 20'd100, cyc);
        idle(20);
        check("abort_lost_cnt", 32'(lost_cnt), 2);

        // Gating: no baseline, full-scale input.
        bl_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(14'd16383);
            @(negedge clk);
            check("gate_busy", 32'(busy), 0);
        end
        idle(3);
        bl_done = 1'b1;
        idle(5);
        check("gate_no_event", 32'(evt_valid), 0);

        // Reset mid-capture clears everything and yields no event.
        step(14'd1100);
        idle(3);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",     32'(busy),      0);
        check("midrst_valid",    32'(evt_valid), 0);
        check("midrst_lost_cnt", 32'(lost_cnt),  0);
        check("midrst_peak",     32'(evt_peak),  0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
